// File: rtl/byte_serial_add_seq.sv
// Purpose: slices wide add/sub requests into bytes and drives an external registered 8-bit adder, chaining carry.
// Latency: accept edge to out_valid is 2*NBYTES+1 cycles; one op per 2*NBYTES+1 cycles when out_ready stays high.
// Backpressure: in_ready only in IDLE or DONE&out_ready; the result is held in DONE until out_ready.
module byte_serial_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] in_a,
   input  logic [8*NBYTES-1:0] in_b,
   input  logic                in_sub,
   input  logic                in_cin,
   output logic [7:0]          add_a,
   output logic [7:0]          add_b,
   output logic                add_cin,
   input  logic [7:0]          add_sum,
   input  logic                add_cout,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] out_sum,
   output logic                out_cout,
   output logic                out_ovf
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   // Operands and result viewed as byte lanes, lane 0 is the LSB.
   typedef logic [NBYTES-1:0][7:0] bytes_t;

   state_t        state;
   bytes_t        a_q;
   bytes_t        b_q;
   bytes_t        sum_q;
   logic [IW-1:0] idx;
   logic          carry;

   logic          accept;
   logic [IW-1:0] idx_nxt;
   bytes_t        in_a_bytes;
   bytes_t        in_b_eff;
   logic          cin_eff;

   // Subtraction is A + ~B + 1, so B is inverted once at acceptance.
   assign in_a_bytes = in_a;
   assign in_b_eff   = in_b ^ {W{in_sub}};
   assign cin_eff    = in_sub | in_cin;
   assign idx_nxt    = idx + 1'b1;

   // DONE can hand off its result and take the next request in the same cycle.
   assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
   assign accept   = in_valid & in_ready;
   assign out_sum  = sum_q;

   // Sequencer FSM; adder drive and result fields are all registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
         add_cin   <= 1'b0;
         out_valid <= 1'b0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: ;
            // Adder inputs were set when entering ISSUE; the adder registers them this edge.
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               sum_q[idx] <= add_sum;
               carry      <= add_cout;
               if (idx != LAST_IDX) begin
                  idx     <= idx_nxt;
                  add_a   <= a_q[idx_nxt];
                  add_b   <= b_q[idx_nxt];
                  add_cin <= add_cout;
                  state   <= S_ISSUE;
               end else begin
                  out_cout  <= add_cout;
                  // Signed overflow: same-sign operands producing a result of the other sign.
                  out_ovf   <= (a_q[NBYTES-1][7] == b_q[NBYTES-1][7]) &
                               (add_sum[7] != a_q[NBYTES-1][7]);
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // New request: latch operands and present byte 0 immediately so it is stable through ISSUE.
         if (accept) begin
            a_q     <= in_a_bytes;
            b_q     <= in_b_eff;
            carry   <= cin_eff;
            idx     <= '0;
            add_a   <= in_a_bytes[0];
            add_b   <= in_b_eff[0];
            add_cin <= cin_eff;
            state   <= S_ISSUE;
         end
      end
   end

endmodule

// File: tb/tb_byte_serial_add_seq.sv
// Bench for byte_serial_add_seq with NBYTES=4 and a 1-cycle registered 8-bit adder model.
// Expected results are queued at request acceptance and compared when the result is presented.
// Covers reset, add/sub directed cases, backpressure hold, back-to-back handoff and reset mid-op.
module tb_byte_serial_add_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_sub;
   logic        in_cin;
   logic [7:0]  add_a;
   logic [7:0]  add_b;
   logic        add_cin;
   logic [7:0]  add_sum;
   logic        add_cout;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_cout;
   logic        out_ovf;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   byte_serial_add_seq #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_sub    (in_sub),
      .in_cin    (in_cin),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered 8-bit adder stage.
   always @(posedge clk) begin
      {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
   end

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin);
      logic [31:0] bp;
      logic [32:0] full;
      exp_t        e;
      bp     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bp} + {32'd0, (sub ? 1'b1 : cin)};
      e.sum  = full[31:0];
      e.cout = full[32];
      e.ovf  = (a[31] == bp[31]) && (full[31] != a[31]);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic cin);
      int n;
      n = 0;
      in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_wait", {63'd0, (n < 100)}, 64'd1);
      sb.push_back(model(a, b, sub, cin));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom; in_sub = 1'(($urandom)); in_cin = 1'(($urandom));
   endtask

   // Waits for the result with out_ready high, checks it, and returns latency from accept edge.
   task automatic get_result(input string tag, output int lat);
      int   n;
      exp_t e;
      n = 0;
      out_ready = 1'b1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      lat = n + 1;
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_sum"},  {32'd0, out_sum},  {32'd0, e.sum});
         chk({tag, "_cout"}, {63'd0, out_cout}, {63'd0, e.cout});
         chk({tag, "_ovf"},  {63'd0, out_ovf},  {63'd0, e.ovf});
      end
      @(posedge clk); #1;
      chk({tag, "_vld_drop"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      int   lat;
      int   n;
      exp_t e;
      logic [31:0] a2;
      logic [31:0] b2;

      rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_sum",   {32'd0, out_sum},   64'd0);
      chk("rst_out_cout",  {63'd0, out_cout},  64'd0);
      chk("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
      chk("rst_add_a",     {56'd0, add_a},     64'd0);
      chk("rst_add_b",     {56'd0, add_b},     64'd0);
      chk("rst_add_cin",   {63'd0, add_cin},   64'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready",  {63'd0, in_ready},  64'd1);

      // Byte carry into byte 1, with latency check.
      do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      get_result("add_ff_1", lat);
      chk("add_latency", lat, 64'd9);

      // Carry ripples through every byte.
      do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
      get_result("ripple", lat);

      // Subtractions: borrow, and signed overflow at the negative limit.
      do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
      get_result("sub_5_7", lat);
      do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
      get_result("sub_min_1", lat);
      // Positive overflow on add.
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      get_result("add_pos_ovf", lat);

      // Random mix.
      for (int i = 0; i < 6; i++) begin
         do_op($urandom, $urandom, 1'((i >> 1)), 1'(i));
         get_result("rand", lat);
      end

      // Backpressure: result held with out_ready low while a new request waits.
      out_ready = 1'b0;
      do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("bp_valid_rise", {63'd0, out_valid}, 64'd1);
      a2 = 32'hA5A5_5AC3; b2 = 32'h0000_0F11;
      in_a = a2; in_b = b2; in_sub = 1'b1; in_cin = 1'b0; in_valid = 1'b1;
      e = sb[0];
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_hold_sum",   {32'd0, out_sum},   {32'd0, e.sum});
         chk("bp_in_ready",   {63'd0, in_ready},  64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
      e = sb.pop_front();
      chk("bp_sum",  {32'd0, out_sum},  {32'd0, e.sum});
      chk("bp_cout", {63'd0, out_cout}, {63'd0, e.cout});
      chk("bp_ovf",  {63'd0, out_ovf},  {63'd0, e.ovf});
      sb.push_back(model(a2, b2, 1'b1, 1'b0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("b2b_valid_drop", {63'd0, out_valid}, 64'd0);
      chk("b2b_add_a",      {56'd0, add_a},     {56'd0, a2[7:0]});
      chk("b2b_add_b",      {56'd0, add_b},     {56'd0, ~b2[7:0]});
      chk("b2b_add_cin",    {63'd0, add_cin},   64'd1);
      chk("b2b_busy",       {63'd0, in_ready},  64'd0);
      get_result("b2b", lat);
      chk("b2b_latency", lat, 64'd9);

      // Reset during the third WAIT (5 edges after accept).
      do_op(32'h1111_2233, 32'h0101_0101, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      void'(sb.pop_back());
      chk("mid_rst_valid",  {63'd0, out_valid}, 64'd0);
      chk("mid_rst_sum",    {32'd0, out_sum},   64'd0);
      chk("mid_rst_add_a",  {56'd0, add_a},     64'd0);
      chk("mid_rst_ready",  {63'd0, in_ready},  64'd1);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (out_valid) n++;
      end
      chk("no_partial_result", n, 64'd0);
      do_op(32'h0F0F_F0F0, 32'h00FF_FF10, 1'b0, 1'b1);
      get_result("after_rst", lat);
      chk("after_rst_latency", lat, 64'd9);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
